// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port integer register file.
// Used by regfile_mp, its scoreboard and its bus interface.
package rf_pkg;

    // Default geometry of the riscv64 integer file
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NR_DEF    = 2;
    localparam int NW_DEF    = 2;

    // CLEAR sweeps the array to zero after reset, RUN is normal operation
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

    // One architectural register at the default width
    typedef logic [XLEN_DEF-1:0] reg_t;

    // Address width for a file of n registers
    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage : rf_pkg

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave):
// read ports, write ports, scoreboard set and the init-busy flag.
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NR    = NR_DEF,
    parameter int NW    = NW_DEF
);
    localparam int AW = rf_aw(NREGS);

    logic [NR-1:0]      rd_en;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR*XLEN-1:0] rd_data;
    logic [NR-1:0]      rd_pend;
    logic [NW-1:0]      wr_en;
    logic [NW*AW-1:0]   wr_addr;
    logic [NW*XLEN-1:0] wr_data;
    logic               sb_set_en;
    logic [AW-1:0]      sb_set_addr;
    logic               init_busy;

    // Pipeline side: issues reads, writes and scoreboard sets
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_pend, init_busy
    );

    // Register file side
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, rd_pend, init_busy
    );

endinterface : regfile_mp_if

// File: rtl/rf_scoreboard.sv
// Per-register pending bits for decode hazard checks. Accepted writes clear
// their destination, an issue sets its destination; the set wins on a tie
// because it belongs to the newer producer. Bit 0 (x0) is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NW    = NW_DEF,
    parameter int AW    = rf_aw(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic [NW-1:0]    clr_en_i,
    input  logic [NW*AW-1:0] clr_addr_i,
    output logic [NREGS-1:0] pend_o
);

    logic [NREGS-1:0] sb_q;
    logic [NREGS-1:0] sb_d;

    // Next scoreboard: clears first, then the set so it overrides a clear
    always_comb begin
        // NOTE: every bit gets a default before the conditional updates, so no path leaves sb_d unassigned and no latch is inferred.
        sb_d = sb_q;
        for (int j = 0; j < NW; j++) begin
            if (clr_en_i[j]) begin
                sb_d[clr_addr_i[j*AW +: AW]] = 1'b0;
            end
        end
        if (set_en_i) begin
            sb_d[set_addr_i] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Pending-bit register with synchronous clear
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign pend_o = sb_q;

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file: NR registered read ports,
// NW write ports (higher index wins), hardwired-zero x0, a post-reset clear
// sweep over the array and a pending scoreboard.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data and
// the post-update pending bit to reads; otherwise reads see old contents.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NR    = NR_DEF,
    parameter int NW    = NW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);

    localparam int AW = rf_aw(NREGS);

    rf_state_e         state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              init_busy;
    logic              run;

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [NREGS-1:0]  sb_q;

    logic [NW-1:0]     wr_acc;
    logic              sb_set_acc;

    logic [AW-1:0]     rd_addr_a [NR];
    logic [AW-1:0]     wr_addr_a [NW];
    logic [XLEN-1:0]   wr_data_a [NW];

    logic [NR*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NR-1:0]      rd_pend_q, rd_pend_d;

    // Unpack the flat port buses into per-port views
    for (genvar i = 0; i < NR; i++) begin : g_rd_unpack
        assign rd_addr_a[i] = bus.rd_addr[i*AW +: AW];
    end
    for (genvar j = 0; j < NW; j++) begin : g_wr_unpack
        assign wr_addr_a[j] = bus.wr_addr[j*AW +: AW];
        assign wr_data_a[j] = bus.wr_data[j*XLEN +: XLEN];
    end

    // Clear-sweep FSM state register; reset restarts the sweep at index 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Clear-sweep FSM next state and busy flag; one register per cycle
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        init_busy = 1'b0;
        case (state_q)
            CLEAR: begin
                init_busy = 1'b1;
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                init_busy = 1'b0;
            end
            default: begin
                state_d   = CLEAR;
                clr_idx_d = '0;
            end
        endcase
    end

    assign run = (state_q == RUN);

    // Writes and issues only count in RUN; anything aimed at x0 is dropped
    always_comb begin
        wr_acc = '0;
        for (int j = 0; j < NW; j++) begin
            wr_acc[j] = run && bus.wr_en[j] && (wr_addr_a[j] != '0);
        end
        sb_set_acc = run && bus.sb_set_en && (bus.sb_set_addr != '0);
    end

    // Register array: sweep writes zero in CLEAR, ports write in RUN
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; the CLEAR sweep zeroes it one entry per cycle so it can map to plain storage without a wide reset fan-out.
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs_q[clr_idx_q] <= '0;
            end else begin
                // Later iterations override earlier ones: highest port wins
                for (int j = 0; j < NW; j++) begin
                    if (wr_acc[j]) begin
                        regs_q[wr_addr_a[j]] <= wr_data_a[j];
                    end
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NW    (NW),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (sb_set_acc),
        .set_addr_i (bus.sb_set_addr),
        .clr_en_i   (wr_acc),
        .clr_addr_i (bus.wr_addr),
        .pend_o     (sb_q)
    );

    // Read-port next values: zero outside RUN, hold when not enabled
    always_comb begin
        rd_data_d = rd_data_q;
        rd_pend_d = rd_pend_q;
        if (!run) begin
            rd_data_d = '0;
            rd_pend_d = '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (bus.rd_en[i]) begin
                    rd_data_d[i*XLEN +: XLEN] = regs_q[rd_addr_a[i]];
                    rd_pend_d[i]              = sb_q[rd_addr_a[i]];
`ifdef RF_BYPASS_EN
                    // Forward the winning same-cycle write and mirror the
                    // scoreboard update: clear first, then set
                    for (int j = 0; j < NW; j++) begin
                        if (wr_acc[j] && (wr_addr_a[j] == rd_addr_a[i])) begin
                            rd_data_d[i*XLEN +: XLEN] = wr_data_a[j];
                            rd_pend_d[i]              = 1'b0;
                        end
                    end
                    if (sb_set_acc && (bus.sb_set_addr == rd_addr_a[i])) begin
                        rd_pend_d[i] = 1'b1;
                    end
`endif
                    if (rd_addr_a[i] == '0) begin
                        rd_data_d[i*XLEN +: XLEN] = '0;
                        rd_pend_d[i]              = 1'b0;
                    end
                end
            end
        end
    end

    // Registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
            rd_pend_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_pend   = rd_pend_q;
    assign bus.init_busy = init_busy;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp at default geometry (64b, 32 regs, 2R/2W).
// Expected values are hand-derived; RF_BYPASS_EN selects the forwarding cases.
module tb_regfile_mp;
    import rf_pkg::*;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int AW    = 5;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NR(NR), .NW(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_en       = '0;
        bus.rd_addr     = '0;
        bus.wr_en       = '0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.sb_set_en   = 1'b0;
        bus.sb_set_addr = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [63:0] d);
        bus.wr_en[p]             = 1'b1;
        bus.wr_addr[p*AW +: AW]  = a[AW-1:0];
        bus.wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en[p]            = 1'b1;
        bus.rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic sb_set(input int a);
        bus.sb_set_en   = 1'b1;
        bus.sb_set_addr = a[AW-1:0];
    endtask

    function automatic logic [63:0] rdata(input int p);
        return bus.rd_data[p*XLEN +: XLEN];
    endfunction

    // Count init_busy cycles (bounded) and expect exactly NREGS of them
    task automatic wait_sweep(input string tag);
        int cnt = 0;
        while (bus.init_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check({tag, "_busy_len"}, 64'(cnt), 64'(NREGS));
        check({tag, "_busy_low"}, 64'(bus.init_busy), 64'd0);
    endtask

    // Read every register pairwise and expect zero data, zero pend
    task automatic check_all_zero(input string tag);
        for (int a = 0; a < NREGS; a += 2) begin
            idle();
            rd(0, a);
            rd(1, a + 1);
            tick();
            check($sformatf("%s_x%0d", tag, a), rdata(0), 64'd0);
            check($sformatf("%s_x%0d", tag, a + 1), rdata(1), 64'd0);
            check($sformatf("%s_pend", tag), 64'(bus.rd_pend), 64'd0);
        end
    endtask

    initial begin
        reg_t v;
        idle();

        // 1. Reset, sweep length, writes/sets ignored during sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 64'(bus.init_busy), 64'd1);
        check("rst_rdata", 64'(bus.rd_data), 64'd0);
        wr(0, 2, 64'h77);
        sb_set(2);
        rd(1, 0);
        wait_sweep("init");
        idle();
        check_all_zero("init");

        // 2. Simple write then read
        v = 64'hDEAD_BEEF_0000_0001;
        wr(0, 5, v);
        tick();
        idle();
        rd(0, 5);
        tick();
        check("wr_x5", rdata(0), v);

        // 3. Write-port collision (port 1 wins) and x0 write dropped
        idle();
        wr(0, 7, 64'h11);
        wr(1, 7, 64'h22);
        tick();
        idle();
        wr(0, 0, 64'h33);
        tick();
        idle();
        rd(0, 7);
        rd(1, 0);
        tick();
        check("collide_x7", rdata(0), 64'h22);
        check("x0_zero", rdata(1), 64'd0);
        check("x0_pend", 64'(bus.rd_pend[1]), 64'd0);

        // Read enable low holds the previous output
        idle();
        bus.rd_addr[0 +: AW] = 5'd5;
        tick();
        check("hold_x7", rdata(0), 64'h22);

        // Collision with roles swapped: port 1 still wins
        idle();
        wr(1, 12, 64'h55);
        wr(0, 12, 64'h66);
        tick();
        idle();
        rd(1, 12);
        tick();
        check("collide_x12", rdata(1), 64'h55);

        // 4. Scoreboard set, clear by write, set beats clear
        idle();
        sb_set(9);
        tick();
        idle();
        rd(0, 9);
        tick();
        check("sb_set_x9", 64'(bus.rd_pend[0]), 64'd1);
        idle();
        wr(0, 9, 64'h99);
        tick();
        idle();
        rd(0, 9);
        tick();
        check("sb_clr_x9", 64'(bus.rd_pend[0]), 64'd0);
        check("sb_clr_data", rdata(0), 64'h99);
        idle();
        sb_set(9);
        wr(1, 9, 64'hAA);
        tick();
        idle();
        rd(0, 9);
        tick();
        check("sb_setwins", 64'(bus.rd_pend[0]), 64'd1);
        check("sb_setwins_d", rdata(0), 64'hAA);
        idle();
        sb_set(0);
        tick();
        idle();
        rd(1, 0);
        tick();
        check("sb_x0", 64'(bus.rd_pend[1]), 64'd0);

        // 5. Read during write: forwarded or old value
        idle();
        wr(0, 3, 64'h44);
        rd(1, 3);
        tick();
        check("rdw_x3", rdata(1), BYP ? 64'h44 : 64'h0);
        check("rdw_x3_pend", 64'(bus.rd_pend[1]), 64'd0);
        idle();
        rd(1, 3);
        tick();
        check("rdw_x3_next", rdata(1), 64'h44);
        idle();
        sb_set(10);
        rd(0, 10);
        tick();
        check("rdw_pend_x10", 64'(bus.rd_pend[0]), BYP ? 64'd1 : 64'd0);
        idle();
        rd(0, 10);
        tick();
        check("pend_x10_next", 64'(bus.rd_pend[0]), 64'd1);

        // 6. Reset mid-sweep at index 10 restarts a full sweep
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("mid_busy", 64'(bus.init_busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_sweep("restart");
        check_all_zero("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_regfile_mp
